// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and policy codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational priority picker. In round-robin mode the scan starts just
// above the base pointer and wraps; otherwise the lowest index wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] base,
    input  logic          rr_mode,
    output logic          found,
    output logic [GW-1:0] idx
);

    // Scan the request vector in policy order and keep the first hit.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = '0;
        if (rr_mode) begin
            for (int k = 1; k <= N; k++) begin
                c = (int'(base) + k) % N;
                if (!found && req[c]) begin
                    found = 1'b1;
                    idx   = GW'(c);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    idx   = GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one memory port. Grants are decided only in IDLE,
// the winner's payload is latched and held until the memory accepts it, and
// one outstanding read is tracked so the returned data reaches its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int ADDRW = 32,
    parameter int DATAW = 32,
    parameter int MODE  = 0,
    parameter int GW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 force_en,
    input  logic [GW-1:0]        force_ch,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH-1:0]       ch_we,
    input  logic [NCH*ADDRW-1:0] ch_addr,
    input  logic [NCH*DATAW-1:0] ch_wdata,
    output logic [NCH-1:0]       ch_ack,
    output logic [NCH-1:0]       ch_rvalid,
    output logic [DATAW-1:0]     ch_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRW-1:0]     mem_addr,
    output logic [DATAW-1:0]     mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DATAW-1:0]     mem_rdata,
    output logic                 busy
);

    arb_state_t       state_reg, state_next;
    logic [GW-1:0]    grant_reg, grant_next;
    logic [GW-1:0]    ptr_reg, ptr_next;
    logic             we_reg, we_next;
    logic [ADDRW-1:0] addr_reg, addr_next;
    logic [DATAW-1:0] wdata_reg, wdata_next;

    logic [ADDRW-1:0] addr_arr  [NCH];
    logic [DATAW-1:0] wdata_arr [NCH];
    logic [NCH-1:0]   eligible;
    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic             ack_fire;
    logic             rv_fire;

    assign ack_fire = (state_reg == ISSUE) && mem_ready;
    assign rv_fire  = (state_reg == WAIT_RD) && mem_rvalid;

    // Per-channel unpacking, force masking and one-hot response steering.
    // An out-of-range force_ch matches no channel, so nothing is eligible.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign addr_arr[gi]  = ch_addr[gi*ADDRW +: ADDRW];
            assign wdata_arr[gi] = ch_wdata[gi*DATAW +: DATAW];
            assign eligible[gi]  = ch_req[gi] & (~force_en | (force_ch == GW'(gi)));
            assign ch_ack[gi]    = ack_fire & (grant_reg == GW'(gi));
            assign ch_rvalid[gi] = rv_fire & (grant_reg == GW'(gi));
        end
    endgenerate

    rr_pick #(
        .N  (NCH),
        .GW (GW)
    ) u_pick (
        .req     (eligible),
        .base    (ptr_reg),
        .rr_mode (MODE == ARB_RR),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign mem_req   = (state_reg == ISSUE);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign ch_rdata  = mem_rdata;
    assign busy      = (state_reg != IDLE);

    // State, grant, pointer and latched payload registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= GW'(NCH - 1);
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Next-state logic: grant in IDLE, hand off on ready, finish on read data.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    we_next    = ch_we[pick_idx];
                    addr_next  = addr_arr[pick_idx];
                    wdata_next = wdata_arr[pick_idx];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    if (MODE == ARB_RR) begin
                        ptr_next = grant_reg;
                    end
                    state_next = we_reg ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one data-memory port among several masters (channel 0 = IO loader, channel 1 = core, others = future DMA/debug).
- Generalises the static IO/processor select into request/acknowledge handshakes with fixed-priority or round-robin arbitration, a forced-owner override, and tracking of one outstanding transaction, including read-data return.
- Sits between the masters and the BRAM/cache controller.

Parameters:
- NCH, 2, number of requesting channels (>=2).
- ADDRW, 32, address width.
- DATAW, 32, data width.
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
- GW, $clog2(NCH), grant index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- force_en  in  1  restricts grant to force_ch (IO ownership).
- force_ch  in  GW  forced owner index.
- ch_req  in  NCH  per-channel request; must stay high with stable payload until ch_ack.
- ch_we  in  NCH  per-channel write enable.
- ch_addr  in  NCH*ADDRW  flattened addresses; channel i at [i*ADDRW +: ADDRW].
- ch_wdata  in  NCH*DATAW  flattened write data.
- ch_ack  out  NCH  one-hot, one-cycle pulse when memory accepts the channel's request.
- ch_rvalid  out  NCH  one-hot, one-cycle pulse carrying read data.
- ch_rdata  out  DATAW  read data, shared by all channels.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDRW  address to memory.
- mem_wdata  out  DATAW  write data to memory.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATAW  read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rstn low): state = IDLE; mem_req, mem_we, ch_ack, ch_rvalid, busy = 0; mem_addr, mem_wdata = 0; grant register = 0; round-robin pointer = NCH-1, so channel 0 has first priority. This takes effect immediately, mid-transaction included. A pending memory response is dropped; the memory controller shares rstn.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - The eligible set is ch_req masked to force_ch when force_en = 1; otherwise it is all of ch_req.
  - If the eligible set is non-empty, pick a winner g:
    - MODE 0: lowest index.
    - MODE 1: first requester scanning from pointer+1 upward, wrapping modulo NCH.
  - Register g and the winner's we/addr/wdata into the mem_* outputs, assert mem_req, go to ISSUE.
  - Latency: a ch_req seen at edge k gives mem_req high after edge k.
  - If force_en = 1 and force_ch is not requesting, stay in IDLE; other requests stall.
- ISSUE:
  - Hold mem_req and the payload stable until mem_ready.
  - In the mem_ready cycle, ch_ack[g] = 1, combinational from mem_ready and state.
  - At the next edge: mem_req = 0. MODE 1 sets pointer = g.
  - If the access is a write, go to IDLE; if a read, go to WAIT_RD.
- WAIT_RD:
  - ch_rvalid[g] = mem_rvalid, combinational; ch_rdata = mem_rdata, pass-through.
  - On mem_rvalid, go to IDLE.
- Back-to-back: the minimum write period is 2 cycles per transaction (IDLE, ISSUE with immediate ready). A new grant is evaluated only in IDLE.
- mem_rvalid is ignored in IDLE and ISSUE. Memory guarantees rvalid arrives at least 1 cycle after ready.
- A change in force_en or force_ch during ISSUE or WAIT_RD does not abort the current transaction; it applies at the next IDLE.
- A requester dropping ch_req before ack is a protocol violation. The latched payload still completes, and ack still pulses.
- ch_ack and ch_rvalid are never asserted for a non-granted channel. At most one bit of each is set.
- Out-of-range force_ch (>= NCH) with force_en = 1 means no grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2);
  - the MODE constants ARB_FIXED = 0 and ARB_RR = 1.
- One natural sub-module: rr_pick, a combinational priority picker.
  - Inputs: request vector, base pointer, mode.
  - Outputs: found flag and index.
  - It is instantiated once.

Test Plan:
- NCH = 2, MODE = 0. Ch1 writes addr 0x10, data 0xDEAD; mem_ready high on the first ISSUE cycle -> mem_req high for exactly 1 cycle with mem_we = 1, addr 0x10, data 0xDEAD; ch_ack = 2'b10 in that cycle; busy falls after 2 cycles.
- NCH = 4, MODE = 1. All channels request reads continuously; memory gives rvalid 2 cycles after ready with rdata = addr -> grant order 0,1,2,3,0; each ch_rvalid pulse carries that channel's address.
- MODE = 0. Ch0 and ch1 both request repeatedly -> ch0 always wins and ch1 starves while ch0 holds req. After ch0 drops, ch1 is granted at the next IDLE.
- force_en = 1, force_ch = 0 with only ch1 requesting -> no mem_req for 10 cycles. Ch0 then requests -> granted. Clearing force_en lets ch1 proceed.
- Read issued, then rstn pulsed low during WAIT_RD -> mem_req, busy and ch_* outputs go to 0 asynchronously; a late mem_rvalid produces no ch_rvalid; the next request is serviced normally.
- mem_ready held low 5 cycles in ISSUE while force_ch changes -> payload and grant stay stable, and the ack goes to the original channel.
